// File: rtl/counter_pkg.sv
// Shared types for the counter bank.
// Channel FSM states and count modes.
package counter_pkg;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

  typedef enum logic {
    MODE_ONESHOT,
    MODE_RELOAD
  } mode_e;

endpackage

// File: rtl/counter_ch.sv
// One counter channel: start/stop FSM, terminal detection,
// sticky done and overrun flags.
module counter_ch
  import counter_pkg::*;
#(
  parameter int WIDTH_CNT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 en,
  input  logic                 mode,
  input  logic [WIDTH_CNT-1:0] term,
  input  logic                 ack,
  output logic                 busy,
  output logic [WIDTH_CNT-1:0] count,
  output logic                 done,
  output logic                 overrun
);

  ch_state_e            state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [WIDTH_CNT-1:0] count_q, count_d;
  logic [WIDTH_CNT-1:0] term_q, term_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic run;
  logic at_term;
  logic do_stop;
  logic do_start;
  logic do_term;
  logic do_inc;

  assign run      = (state_q == CH_RUN);
  assign at_term  = (count_q == term_q);
  assign do_stop  = stop;
  assign do_start = start & ~stop;
  assign do_term  = run & en & at_term & ~stop & ~start;
  assign do_inc   = run & en & ~at_term & ~stop & ~start;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    term_d  = term_q;
    unique case (1'b1)
      do_stop: begin
        state_d = CH_IDLE;
      end
      do_start: begin
        state_d = CH_RUN;
        count_d = '0;
        term_d  = term;
        mode_d  = mode_e'(mode);
      end
      do_term: begin
        if (mode_q == MODE_RELOAD) begin
          count_d = '0;
        end else begin
          state_d = CH_IDLE;
        end
      end
      do_inc: begin
        count_d = count_q + WIDTH_CNT'(1);
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // A set that coincides with ack wins, so no event is lost.
  always_comb begin
    done_d = do_term | (done_q & ~ack);
    ovr_d  = (do_term & done_q & ~ack) | (ovr_q & ~ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      mode_q  <= MODE_ONESHOT;
      count_q <= '0;
      term_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      term_q  <= term_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = run;
  assign count   = count_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counter channels with a shared
// interrupt formed from the done flags.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH_CNT = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             stop_i,
  input  logic [NUM_CH-1:0]             en_i,
  input  logic [NUM_CH-1:0]             mode_i,
  input  logic [NUM_CH*WIDTH_CNT-1:0]   term_i,
  input  logic [NUM_CH-1:0]             ack_i,
  output logic [NUM_CH-1:0]             busy_o,
  output logic [NUM_CH*WIDTH_CNT-1:0]   count_o,
  output logic [NUM_CH-1:0]             done_o,
  output logic [NUM_CH-1:0]             overrun_o,
  output logic                          irq_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    counter_ch #(
      .WIDTH_CNT(WIDTH_CNT)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .start  (start_i[c]),
      .stop   (stop_i[c]),
      .en     (en_i[c]),
      .mode   (mode_i[c]),
      .term   (term_i[c*WIDTH_CNT +: WIDTH_CNT]),
      .ack    (ack_i[c]),
      .busy   (busy_o[c]),
      .count  (count_o[c*WIDTH_CNT +: WIDTH_CNT]),
      .done   (done_o[c]),
      .overrun(overrun_o[c])
    );
  end

  assign irq_o = |done_o;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios
// plus random traffic against a behavioural channel model.
module tb_counter_bank;

  localparam int N = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   start_i, stop_i, en_i, mode_i, ack_i;
  logic [N*W-1:0] term_i;
  logic [N-1:0]   busy_o, done_o, overrun_o;
  logic [N*W-1:0] count_o;
  logic           irq_o;

  int checks = 0;
  int errors = 0;

  bit m_run[N];
  int m_cnt[N];
  int m_trm[N];
  bit m_md[N];
  bit m_dn[N];
  bit m_ov[N];

  counter_bank #(
    .NUM_CH(N),
    .WIDTH_CNT(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .en_i     (en_i),
    .mode_i   (mode_i),
    .term_i   (term_i),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .count_o  (count_o),
    .done_o   (done_o),
    .overrun_o(overrun_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_cnt[c] = 0; m_trm[c] = 0;
      m_md[c] = 0; m_dn[c] = 0; m_ov[c] = 0;
    end
  endtask

  // One clock of the channel rules, read straight from the inputs.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit hit;
      hit = 0;
      if (stop_i[c]) begin
        m_run[c] = 0;
      end else if (start_i[c]) begin
        m_run[c] = 1;
        m_cnt[c] = 0;
        m_trm[c] = int'(term_i[c*W +: W]);
        m_md[c]  = mode_i[c];
      end else if (m_run[c] && en_i[c]) begin
        if (m_cnt[c] == m_trm[c]) begin
          hit = 1;
          if (m_md[c]) m_cnt[c] = 0;
          else m_run[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      m_ov[c] = (hit && m_dn[c] && !ack_i[c]) || (m_ov[c] && !ack_i[c]);
      m_dn[c] = hit || (m_dn[c] && !ack_i[c]);
    end
  endtask

  task automatic compare_all(string tag);
    logic [N-1:0]   eb, ed, eo;
    logic [N*W-1:0] ec;
    for (int c = 0; c < N; c++) begin
      eb[c] = m_run[c];
      ed[c] = m_dn[c];
      eo[c] = m_ov[c];
      ec[c*W +: W] = W'(m_cnt[c]);
    end
    check({tag, ".busy"}, 64'(busy_o), 64'(eb));
    check({tag, ".count"}, 64'(count_o), 64'(ec));
    check({tag, ".done"}, 64'(done_o), 64'(ed));
    check({tag, ".ovr"}, 64'(overrun_o), 64'(eo));
    check({tag, ".irq"}, 64'(irq_o), 64'(|ed));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic clear_in();
    start_i = '0; stop_i = '0; en_i = '0;
    mode_i = '0; ack_i = '0; term_i = '0;
  endtask

  task automatic set_term(int c, int v);
    term_i[c*W +: W] = W'(v);
  endtask

  function automatic logic [W-1:0] cnt_of(int c);
    return count_o[c*W +: W];
  endfunction

  initial begin
    rst = 1'b1;
    clear_in();
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;
    tick("idle");

    // one-shot, term 3
    set_term(0, 3); mode_i[0] = 0; start_i[0] = 1;
    tick("os_start");
    start_i[0] = 0; en_i[0] = 1;
    for (int i = 0; i < 4; i++) tick("os_run");
    check("os_count", 64'(cnt_of(0)), 64'd3);
    check("os_done", 64'(done_o[0]), 64'd1);
    check("os_busy", 64'(busy_o[0]), 64'd0);
    tick("os_hold"); tick("os_hold");
    check("os_hold_count", 64'(cnt_of(0)), 64'd3);
    en_i[0] = 0; ack_i[0] = 1;
    tick("os_ack");
    ack_i[0] = 0;

    // auto-reload with overrun, term 2
    set_term(1, 2); mode_i[1] = 1; start_i[1] = 1;
    tick("ar_start");
    start_i[1] = 0; en_i[1] = 1;
    for (int i = 1; i <= 6; i++) begin
      tick("ar_run");
      if (i == 3) check("ar_done3", 64'(done_o[1]), 64'd1);
      if (i == 5) check("ar_ovr5", 64'(overrun_o[1]), 64'd0);
    end
    check("ar_ovr6", 64'(overrun_o[1]), 64'd1);
    check("ar_count6", 64'(cnt_of(1)), 64'd0);
    tick("ar_run");

    // stop and start together: stop wins
    stop_i[1] = 1; start_i[1] = 1;
    tick("ss");
    stop_i[1] = 0; start_i[1] = 0; en_i[1] = 0;
    check("ss_busy", 64'(busy_o[1]), 64'd0);
    check("ss_count", 64'(cnt_of(1)), 64'd1);

    // term 0, then ack on the terminal cycle
    set_term(2, 0); mode_i[2] = 0; start_i[2] = 1;
    tick("t0_start");
    start_i[2] = 0; en_i[2] = 1;
    tick("t0_hit");
    check("t0_done", 64'(done_o[2]), 64'd1);
    en_i[2] = 0; start_i[2] = 1;
    tick("t0_restart");
    start_i[2] = 0; en_i[2] = 1; ack_i[2] = 1;
    tick("t0_ackhit");
    check("ack_hit_done", 64'(done_o[2]), 64'd1);
    en_i[2] = 0; ack_i = '1;
    tick("ack_all");
    ack_i = '0;

    // term 31: full range, no wrap
    set_term(3, 31); mode_i[3] = 0; start_i[3] = 1;
    tick("t31_start");
    start_i[3] = 0; en_i[3] = 1;
    for (int i = 0; i < 31; i++) tick("t31_run");
    check("t31_cnt31", 64'(cnt_of(3)), 64'd31);
    check("t31_nodone", 64'(done_o[3]), 64'd0);
    tick("t31_hit");
    check("t31_done", 64'(done_o[3]), 64'd1);
    check("t31_hold", 64'(cnt_of(3)), 64'd31);
    en_i[3] = 0; ack_i[3] = 1;
    tick("t31_ack");
    ack_i[3] = 0;

    // asynchronous reset mid-run
    set_term(0, 10); start_i[0] = 1;
    tick("rs_start");
    start_i[0] = 0; en_i[0] = 1;
    tick("rs_run"); tick("rs_run");
    check("rs_cnt2", 64'(cnt_of(0)), 64'd2);
    #3;
    rst = 1'b1;
    #1;
    check("rs_busy", 64'(busy_o), 64'd0);
    check("rs_count", 64'(count_o), 64'd0);
    check("rs_irq", 64'(irq_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick("rs_en"); tick("rs_en");
    check("rs_idle_cnt", 64'(cnt_of(0)), 64'd0);
    en_i[0] = 0;

    // multi-channel independence and irq
    set_term(0, 1); set_term(3, 4);
    mode_i = '0; start_i[0] = 1; start_i[3] = 1;
    tick("mc_start");
    start_i = '0; en_i[0] = 1; en_i[3] = 1;
    tick("mc_run"); tick("mc_run");
    check("mc_d0", 64'(done_o), 64'b0001);
    check("mc_irq", 64'(irq_o), 64'd1);
    for (int i = 0; i < 3; i++) tick("mc_run");
    check("mc_d3", 64'(done_o), 64'b1001);
    ack_i[0] = 1;
    tick("mc_ack0");
    ack_i[0] = 0;
    check("mc_irq_kept", 64'(irq_o), 64'd1);
    clear_in();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++) begin
        start_i[c] = ($urandom_range(0, 15) == 0);
        stop_i[c]  = ($urandom_range(0, 31) == 0);
        en_i[c]    = ($urandom_range(0, 3) != 0);
        ack_i[c]   = ($urandom_range(0, 11) == 0);
        mode_i[c]  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) set_term(c, $urandom_range(0, 31));
        else set_term(c, $urandom_range(0, 4));
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
